// File: rtl/bias_accum_pkg.sv
// Shared widths, saturation limits, FSM state encoding and saturate helpers
// for the bias accumulation stage.
package bias_accum_pkg;

  localparam int DW      = 18;
  localparam int ACC_W   = 24;
  localparam int DW_MAX  = (2 ** (DW - 1)) - 1;
  localparam int DW_MIN  = -(2 ** (DW - 1));
  localparam int ACC_MAX = (2 ** (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(2 ** (ACC_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_BIAS  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef logic signed [DW-1:0]  lane_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  // One guard bit wider than the accumulator so a single add never wraps.
  typedef logic signed [ACC_W:0] acc_sum_t;

  function automatic acc_sum_t sext_dw(input lane_t v);
    return {{(ACC_W + 1 - DW){v[DW-1]}}, v};
  endfunction

  function automatic logic acc_ovf(input acc_sum_t s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic acc_t sat_acc(input acc_sum_t s);
    if (s > acc_sum_t'(ACC_MAX)) begin
      return acc_t'(ACC_MAX);
    end else if (s < acc_sum_t'(ACC_MIN)) begin
      return acc_t'(ACC_MIN);
    end
    return s[ACC_W-1:0];
  endfunction

  function automatic logic dw_ovf(input acc_t a);
    return (a > acc_t'(DW_MAX)) || (a < acc_t'(DW_MIN));
  endfunction

  function automatic lane_t sat_dw(input acc_t a);
    if (a > acc_t'(DW_MAX)) begin
      return lane_t'(DW_MAX);
    end else if (a < acc_t'(DW_MIN)) begin
      return lane_t'(DW_MIN);
    end
    return a[DW-1:0];
  endfunction

endpackage

// File: rtl/bias_accum_lane.sv
// One lane: saturating accumulator, sticky clip flag and the registered,
// saturated (optionally ReLU-clamped) result.
module bias_accum_lane
  import bias_accum_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  add_in_i,
  input  logic  add_bias_i,
  input  logic  capture_i,
  input  logic  relu_i,
  input  lane_t in_i,
  input  lane_t bias_i,
  output lane_t out_o,
  output logic  sat_o
);

  acc_t     acc_q, acc_d;
  lane_t    out_q, out_d;
  logic     sat_q, sat_d;
  acc_sum_t sum;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    out_d = out_q;
    sat_d = sat_q;
    sum   = acc_sum_t'({acc_q[ACC_W-1], acc_q}) + sext_dw(add_bias_i ? bias_i : in_i);

    if (load_i) begin
      acc_d = acc_t'(sext_dw(in_i));
      sat_d = 1'b0;
    end else if (add_in_i || add_bias_i) begin
      acc_d = sat_acc(sum);
      if (acc_ovf(sum)) begin
        sat_d = 1'b1;
      end
    end

    // A negative clip still flags overflow even when ReLU then zeroes the lane.
    if (capture_i) begin
      out_d = sat_dw(acc_q);
      if (dw_ovf(acc_q)) begin
        sat_d = 1'b1;
      end
      if (relu_i && out_d[DW-1]) begin
        out_d = '0;
      end
    end
  end

  // NOTE: the accumulator is ordinary state, not a RAM, so it takes the async reset like the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      acc_q <= acc_d;
      out_q <= out_d;
      sat_q <= sat_d;
    end
  end

  assign out_o = out_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/bias_accum_stage.sv
// Consumer of the per-layer bias bus: accumulates partial-sum passes, adds
// bias, saturates/ReLUs and hands the result on with valid/ready.
module bias_accum_stage #(
  parameter int N_adder_tree = 16,
  parameter int DW           = bias_accum_pkg::DW,
  parameter int ACC_W        = bias_accum_pkg::ACC_W,
  parameter int PASS_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PASS_W-1:0]          cfg_passes,
  input  logic                       relu_en,
  input  logic [N_adder_tree*DW-1:0] bias_q,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*DW-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic                       out_sat,
  output logic                       busy
);

  import bias_accum_pkg::*;

  // Lane arithmetic is fixed by the package; a mismatched override is a build error.
  if (DW != bias_accum_pkg::DW || ACC_W != bias_accum_pkg::ACC_W) begin : g_width_guard
    $error("bias_accum_stage: DW/ACC_W must match bias_accum_pkg");
  end

  state_e              state_q, state_d;
  logic [PASS_W-1:0]   cnt_q, cnt_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic                relu_q, relu_d;
  logic                cap_q, cap_d;
  logic                valid_q, valid_d;
  logic                load, add_in, add_bias, capture;
  logic [N_adder_tree-1:0] lane_sat;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    passes_d = passes_q;
    relu_d   = relu_q;
    cap_d    = cap_q;
    valid_d  = valid_q;
    load     = 1'b0;
    add_in   = 1'b0;
    add_bias = 1'b0;
    capture  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load     = 1'b1;
          passes_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
          relu_d   = relu_en;
          cnt_d    = PASS_W'(1);
          state_d  = (passes_d == PASS_W'(1)) ? ST_BIAS : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          add_in = 1'b1;
          cnt_d  = cnt_q + PASS_W'(1);
          if (cnt_d == passes_q) begin
            state_d = ST_BIAS;
          end
        end
      end
      ST_BIAS: begin
        add_bias = 1'b1;
        cap_d    = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        // First OUT cycle registers the saturated result; valid rises after it.
        if (cap_q) begin
          capture = 1'b1;
          cap_d   = 1'b0;
          valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      passes_q <= '0;
      relu_q   <= 1'b0;
      cap_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      passes_q <= passes_d;
      relu_q   <= relu_d;
      cap_q    <= cap_d;
      valid_q  <= valid_d;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_accum_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .add_in_i   (add_in),
      .add_bias_i (add_bias),
      .capture_i  (capture),
      .relu_i     (relu_q),
      .in_i       (in_data[DW*i +: DW]),
      .bias_i     (bias_q[DW*i +: DW]),
      .out_o      (out_data[DW*i +: DW]),
      .sat_o      (lane_sat[i])
    );
  end

  // Ready depends on state only, never on in_valid or out_ready.
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign out_valid = valid_q;
  assign out_sat   = valid_q & (|lane_sat);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bias_accum_stage.sv
// Scoreboard bench for bias_accum_stage: a lane model predicts each group,
// the monitor compares results as they are handed off.
module tb_bias_accum_stage;

  localparam int     N      = 16;
  localparam int     LW     = 18;
  localparam int     TW     = N * LW;
  localparam longint ACC_HI = 64'sd8388607;
  localparam longint ACC_LO = -64'sd8388608;
  localparam longint DW_HI  = 64'sd131071;
  localparam longint DW_LO  = -64'sd131072;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    cfg_passes;
  logic          relu_en;
  logic [TW-1:0] bias_vec;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          out_sat;
  logic          busy;

  typedef struct {
    logic [TW-1:0] data;
    logic          sat;
  } exp_t;

  exp_t          sb[$];
  logic [TW-1:0] beat_q[$];
  exp_t          mon_e;
  exp_t          stall_e;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_acc = 0;
  logic          prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bias_accum_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_passes (cfg_passes),
    .relu_en    (relu_en),
    .bias_q     (bias_vec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint lane_val(input logic [TW-1:0] v, input int l);
    logic signed [LW-1:0] t;
    t = v[l*LW +: LW];
    return longint'(t);
  endfunction

  function automatic logic [TW-1:0] put_lane(input logic [TW-1:0] v, input int l, input longint val);
    logic [TW-1:0] r;
    r = v;
    r[l*LW +: LW] = val[LW-1:0];
    return r;
  endfunction

  // Reference: sum passes with 24-bit clipping, add bias, clip to 18 bits, ReLU.
  function automatic exp_t model(input bit relu);
    exp_t   e;
    longint acc;
    e.data = '0;
    e.sat  = 1'b0;
    for (int l = 0; l < N; l++) begin
      acc = lane_val(beat_q[0], l);
      for (int k = 1; k <= beat_q.size(); k++) begin
        acc += (k == beat_q.size()) ? lane_val(bias_vec, l) : lane_val(beat_q[k], l);
        if (acc > ACC_HI) begin acc = ACC_HI; e.sat = 1'b1; end
        if (acc < ACC_LO) begin acc = ACC_LO; e.sat = 1'b1; end
      end
      if (acc > DW_HI) begin acc = DW_HI; e.sat = 1'b1; end
      if (acc < DW_LO) begin acc = DW_LO; e.sat = 1'b1; end
      if (relu && acc < 0) acc = 0;
      e.data = put_lane(e.data, l, acc);
    end
    return e;
  endfunction

  // Drives every beat of beat_q (with optional gaps), then checks in_ready is
  // low for the BIAS cycle and the capture cycle. Starts/ends just after a posedge.
  task automatic send_group(input logic [7:0] p_cfg, input bit relu, input int gap,
                            output int first_wait);
    int   w;
    logic rdy;
    sb.push_back(model(relu));
    first_wait = 0;
    cfg_passes = p_cfg;
    relu_en    = relu;
    for (int k = 0; k < beat_q.size(); k++) begin
      if (k > 0) repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = beat_q[k];
      w = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        w++;
      end while (!rdy && w < 200);
      if (!rdy) check("accept_timeout", TW'(rdy), TW'(1));
      last_acc = cyc;
      in_valid = 1'b0;
      if (k == 0) begin
        first_wait = w;
        cfg_passes = p_cfg + 8'd5;
        relu_en    = ~relu;
      end
    end
    @(negedge clk);
    check("bias_in_ready", TW'(in_ready), TW'(0));
    @(negedge clk);
    check("capture_in_ready", TW'(in_ready), TW'(0));
    @(posedge clk);
    #1;
    cfg_passes = p_cfg;
    relu_en    = relu;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("sb_drained", TW'(sb.size()), TW'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) check("latency", TW'(cyc - last_acc), TW'(2));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", TW'(sb.size()), TW'(1));
        end else begin
          mon_e = sb.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_sat", TW'(out_sat), TW'(mon_e.sat));
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int w;
    int r;
    in_valid   = 1'b0;
    in_data    = '0;
    bias_vec   = '0;
    cfg_passes = 8'd1;
    relu_en    = 1'b0;
    out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", TW'(out_valid), TW'(0));
    check("rst_busy", TW'(busy), TW'(0));
    check("rst_out_sat", TW'(out_sat), TW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", TW'(in_ready), TW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pass, bias 5428 + 100 in lane 0.
    bias_vec = put_lane('0, 0, 5428);
    beat_q = {};
    beat_q.push_back(put_lane('0, 0, 100));
    send_group(8'd1, 1'b0, 0, w);
    drain();

    // Three passes with gaps in lane 1, bias -16.
    bias_vec = put_lane('0, 1, -16);
    beat_q = {};
    beat_q.push_back(put_lane('0, 1, 1000));
    beat_q.push_back(put_lane('0, 1, -250));
    beat_q.push_back(put_lane('0, 1, 40));
    send_group(8'd3, 1'b0, 2, w);
    drain();

    // Negative result in lane 2, with and without ReLU.
    bias_vec = put_lane('0, 2, 100);
    beat_q = {};
    beat_q.push_back(put_lane('0, 2, -500));
    beat_q.push_back(put_lane('0, 2, -300));
    send_group(8'd2, 1'b1, 0, w);
    drain();
    send_group(8'd2, 1'b0, 1, w);
    drain();

    // Output clip in lane 3, then a small group to see the flag cleared.
    bias_vec = put_lane('0, 3, 5428);
    beat_q = {};
    beat_q.push_back(put_lane('0, 3, 131071));
    beat_q.push_back(put_lane('0, 3, 131071));
    send_group(8'd2, 1'b0, 0, w);
    drain();
    beat_q = {};
    beat_q.push_back(put_lane('0, 3, 10));
    beat_q.push_back(put_lane('0, 3, 20));
    send_group(8'd2, 1'b0, 0, w);
    drain();

    // cfg_passes of 0 behaves as a single pass.
    bias_vec = '0;
    beat_q = {};
    beat_q.push_back(put_lane('0, 0, -42));
    send_group(8'd0, 1'b0, 0, w);
    drain();

    // Accumulator clip both ways over 70 passes, ReLU on.
    beat_q = {};
    for (int k = 0; k < 70; k++) beat_q.push_back(put_lane(put_lane('0, 5, 131071), 6, -131072));
    send_group(8'd70, 1'b1, 0, w);
    drain();

    // Backpressure: hold out_ready low for 5 cycles while offering beats.
    bias_vec = put_lane('0, 7, 1);
    out_ready = 1'b0;
    beat_q = {};
    beat_q.push_back(put_lane('0, 7, 1234));
    send_group(8'd1, 1'b0, 0, w);
    stall_e = sb[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = put_lane('0, 7, 999);
      @(negedge clk);
      check("stall_out_valid", TW'(out_valid), TW'(1));
      check("stall_out_data", out_data, stall_e.data);
      check("stall_in_ready", TW'(in_ready), TW'(0));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    beat_q = {};
    beat_q.push_back(put_lane('0, 7, 55));
    send_group(8'd1, 1'b0, 0, w);
    check("accept_next_cycle", TW'(w), TW'(1));
    drain();

    // Random groups across all lanes.
    for (int g = 0; g < 3; g++) begin
      bias_vec = '0;
      for (int l = 0; l < N; l++) begin
        r = int'($urandom_range(0, 4000)) - 2000;
        bias_vec = put_lane(bias_vec, l, longint'(r));
      end
      beat_q = {};
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        in_data = '0;
        for (int l = 0; l < N; l++) begin
          r = int'($urandom_range(0, 120000)) - 60000;
          in_data = put_lane(in_data, l, longint'(r));
        end
        beat_q.push_back(in_data);
      end
      send_group(8'(beat_q.size()), 1'($urandom_range(0, 1)), g, w);
      drain();
    end

    // Reset in the middle of a 4-pass group, then a clean group.
    cfg_passes = 8'd4;
    in_valid   = 1'b1;
    in_data    = put_lane('0, 8, 500);
    @(negedge clk);
    check("pre_reset_in_ready", TW'(in_ready), TW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", TW'(busy), TW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", TW'(out_valid), TW'(0));
    check("mid_rst_busy", TW'(busy), TW'(0));
    check("mid_rst_out_sat", TW'(out_sat), TW'(0));
    check("mid_rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bias_vec = '0;
    beat_q = {};
    beat_q.push_back(put_lane('0, 8, 7));
    send_group(8'd1, 1'b0, 0, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
